sr_ff_bank: RTL and testbench

- Parametrised, clocked successor to the single asynchronous SR storage element.
- N independent SR flip-flop channels, all on one clock with synchronous active-high reset.
- A runtime-selectable policy resolves the S=R=1 condition; it is no longer left undefined.
- Tracks invalid-input events with per-channel pulses, a saturating event counter and a sticky error flag; serves as the team's general-purpose set/reset flag register.

---
 rtl/sr_pkg.sv | 34 +++
 rtl/sr_ff_cell.sv | 79 +++++++
 rtl/sr_ff_bank.sv | 69 ++++++
 tb/tb_sr_ff_bank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and next-state rule for the SR flip-flop bank.
// Optional input filter enabled with SR_GLITCH_FILTER_EN (see sr_ff_cell).
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  localparam int FILT_W = 4;

  // S=R=1 is resolved by mode instead of being left undefined.
  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input sr_mode_e mode);
    logic nxt;
    case ({s, r})
      2'b00:   nxt = q;
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      default: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: q/qbar registers, invalid pulse and, with
// SR_GLITCH_FILTER_EN defined, a per-channel input stability filter.
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter logic INIT_BIT    = 1'b0,
  parameter int   FILT_CYCLES = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     s,
  input  logic     r,
  input  sr_mode_e mode,
  output logic     q,
  output logic     qbar,
  output logic     invalid,
  output logic     hit
);

  if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_bad_filt
    $error("sr_ff_cell: FILT_CYCLES must be in 2..15");
  end

  logic eff_s;
  logic eff_r;
  logic nxt;

`ifdef SR_GLITCH_FILTER_EN
  logic [1:0]        pair_prev;
  logic [FILT_W-1:0] run_cnt;
  logic              same;
  logic              stable;

  // run_cnt holds how many consecutive samples pair_prev has been seen;
  // the current sample extends that run by one when it matches.
  always_comb begin
    same   = ({s, r} == pair_prev);
    stable = same && (run_cnt >= FILT_W'(FILT_CYCLES - 1));
    eff_s  = stable & s;
    eff_r  = stable & r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_prev <= 2'b00;
      run_cnt   <= '0;
    end else begin
      pair_prev <= {s, r};
      if (!same)
        run_cnt <= FILT_W'(1);
      else if (run_cnt < FILT_W'(FILT_CYCLES))
        run_cnt <= run_cnt + FILT_W'(1);
    end
  end
`else
  always_comb begin
    eff_s = s;
    eff_r = r;
  end
`endif

  always_comb begin
    hit = eff_s & eff_r;
    nxt = sr_next(eff_s, eff_r, q, mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= INIT_BIT;
      qbar    <= ~INIT_BIT;
      invalid <= 1'b0;
    end else begin
      q       <= nxt;
      qbar    <= ~nxt;
      invalid <= hit;
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// N-channel clocked SR flag register with invalid-event tracking.
// Define SR_GLITCH_FILTER_EN to add the per-channel input stability filter.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int           N           = 8,
  parameter int           CNT_W       = 8,
  parameter logic [N-1:0] INIT        = '0,
  parameter int           FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic [1:0]       mode,
  input  logic             err_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [N-1:0]     invalid,
  output logic [CNT_W-1:0] inv_cnt,
  output logic             err_sticky
);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("sr_ff_bank: N must be in 1..32");
  end

  sr_mode_e     mode_e;
  logic [N-1:0] hit;
  logic         any_hit;

  assign mode_e  = sr_mode_e'(mode);
  assign any_hit = |hit;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_ff_cell #(
      .INIT_BIT    (INIT[i]),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .r       (r[i]),
      .mode    (mode_e),
      .q       (q[i]),
      .qbar    (qbar[i]),
      .invalid (invalid[i]),
      .hit     (hit[i])
    );
  end

  // A fresh event outranks err_clr, so a clear never hides a new error.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (any_hit) begin
      err_sticky <= 1'b1;
      if (err_clr)
        inv_cnt <= CNT_W'(1);
      else if (inv_cnt != '1)
        inv_cnt <= inv_cnt + CNT_W'(1);
    end else if (err_clr) begin
      inv_cnt    <= '0;
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: directed scenarios plus randomized
// traffic against a behavioural model of the flag register.
module tb_sr_ff_bank;
  localparam int           N       = 8;
  localparam int           CNT_W   = 3;
  localparam int           FILT    = 3;
  localparam int           CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [N-1:0] INIT    = 8'hA5;

  logic             clk;
  logic             rst;
  logic [N-1:0]     s;
  logic [N-1:0]     r;
  logic [1:0]       mode;
  logic             err_clr;
  logic [N-1:0]     q;
  logic [N-1:0]     qbar;
  logic [N-1:0]     invalid;
  logic [CNT_W-1:0] inv_cnt;
  logic             err_sticky;

  sr_ff_bank #(
    .N           (N),
    .CNT_W       (CNT_W),
    .INIT        (INIT),
    .FILT_CYCLES (FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .r          (r),
    .mode       (mode),
    .err_clr    (err_clr),
    .q          (q),
    .qbar       (qbar),
    .invalid    (invalid),
    .inv_cnt    (inv_cnt),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_q;
  logic [N-1:0] m_inv;
  int           m_cnt;
  logic         m_err;
  logic [1:0]   hist [N][$];

  // Reference model: one clock edge of the whole bank.
  task automatic model_edge(input logic [N-1:0] s_i, input logic [N-1:0] r_i,
                            input logic [1:0] m_i, input logic clr_i, input logic rst_i);
    logic [N-1:0] es;
    logic [N-1:0] er;
    logic         stable;
    if (rst_i) begin
      m_q   = INIT;
      m_inv = '0;
      m_cnt = 0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) hist[i].delete();
    end else begin
      es = s_i;
      er = r_i;
`ifdef SR_GLITCH_FILTER_EN
      for (int i = 0; i < N; i++) begin
        hist[i].push_back({s_i[i], r_i[i]});
        if (hist[i].size() > FILT) void'(hist[i].pop_front());
        stable = (hist[i].size() == FILT);
        foreach (hist[i][k]) if (hist[i][k] != hist[i][0]) stable = 1'b0;
        if (!stable) begin
          es[i] = 1'b0;
          er[i] = 1'b0;
        end
      end
`endif
      m_inv = es & er;
      for (int i = 0; i < N; i++) begin
        if (es[i] && !er[i]) m_q[i] = 1'b1;
        else if (er[i] && !es[i]) m_q[i] = 1'b0;
        else if (es[i] && er[i]) begin
          if (m_i == 2'd1) m_q[i] = 1'b1;
          else if (m_i == 2'd2) m_q[i] = 1'b0;
          else if (m_i == 2'd3) m_q[i] = ~m_q[i];
        end
      end
      if (m_inv != '0) begin
        m_cnt = clr_i ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
        m_err = 1'b1;
      end else if (clr_i) begin
        m_cnt = 0;
        m_err = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] s_i, input logic [N-1:0] r_i,
                      input logic [1:0] m_i, input logic clr_i, input logic rst_i);
    @(negedge clk);
    s = s_i; r = r_i; mode = m_i; err_clr = clr_i; rst = rst_i;
    @(posedge clk);
    model_edge(s_i, r_i, m_i, clr_i, rst_i);
    #1;
  endtask

  task automatic test_reset();
    step('0, '0, 2'd0, 1'b0, 1'b1);
    checks++;
    if ({q, qbar, invalid, inv_cnt, err_sticky} !== {8'hA5, 8'h5A, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got q=%h qbar=%h inv=%h cnt=%0d err=%b want A5 5A 00 0 0",
               q, qbar, invalid, inv_cnt, err_sticky);
    end
    for (int k = 0; k < 5; k++) begin
      step('0, '0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      checks++;
      if (q !== 8'hA5) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got q=%h want a5", k, q);
      end
    end
  endtask

  task automatic test_set_reset();
    step(8'h01, 8'h00, 2'd0, 1'b0, 1'b0);
    repeat (FILT - 1) if (q[0] !== m_q[0]) ; else ;
`ifndef SR_GLITCH_FILTER_EN
    checks++;
    if (q[0] !== 1'b1 || qbar[0] !== 1'b0) begin
      errors++;
      $display("FAIL set_ch0 got q0=%b qbar0=%b want 1 0", q[0], qbar[0]);
    end
    step(8'h00, 8'h01, 2'd0, 1'b0, 1'b0);
    checks++;
    if (q[0] !== 1'b0 || qbar[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_ch0 got q0=%b qbar0=%b want 0 1", q[0], qbar[0]);
    end
`endif
    checks++;
    if ({q, qbar} !== {m_q, ~m_q}) begin
      errors++;
      $display("FAIL set_reset_model got q=%h qbar=%h want %h %h", q, qbar, m_q, ~m_q);
    end
  endtask

  task automatic test_modes();
    logic [3:0] exp_q;
    exp_q = 4'b0011;
    step('0, '0, 2'd0, 1'b1, 1'b0);
    for (int m = 0; m < 4; m++) begin
      step(8'h08, 8'h00, 2'd0, 1'b0, 1'b0);
      step(8'h08, 8'h08, 2'(m), 1'b0, 1'b0);
`ifndef SR_GLITCH_FILTER_EN
      checks++;
      if (q[3] !== exp_q[m] || invalid[3] !== 1'b1) begin
        errors++;
        $display("FAIL mode_%0d got q3=%b inv3=%b want %b 1", m, q[3], invalid[3], exp_q[m]);
      end
`endif
      checks++;
      if ({q, qbar, invalid, inv_cnt, err_sticky} !== {m_q, ~m_q, m_inv, CNT_W'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL mode_model_%0d got q=%h inv=%h cnt=%0d want %h %h %0d",
                 m, q, invalid, inv_cnt, m_q, m_inv, m_cnt);
      end
    end
`ifndef SR_GLITCH_FILTER_EN
    checks++;
    if (inv_cnt !== 3'd4 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL mode_count got cnt=%0d err=%b want 4 1", inv_cnt, err_sticky);
    end
`endif
  endtask

  task automatic test_saturation();
    step('0, '0, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(8'h22, 8'h22, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      checks++;
      if (inv_cnt !== CNT_W'(m_cnt) || err_sticky !== m_err) begin
        errors++;
        $display("FAIL saturate_%0d got cnt=%0d err=%b want %0d %b", k, inv_cnt, err_sticky, m_cnt, m_err);
      end
    end
    checks++;
    if (inv_cnt !== 3'd7) begin
      errors++;
      $display("FAIL saturate_final got cnt=%0d want 7", inv_cnt);
    end
  endtask

  task automatic test_err_clr();
    logic [N-1:0] q_before;
    step(8'h04, 8'h04, 2'd0, 1'b1, 1'b0);
    step(8'h04, 8'h04, 2'd0, 1'b1, 1'b0);
    step(8'h04, 8'h04, 2'd0, 1'b1, 1'b0);
    checks++;
    if (inv_cnt !== 3'd1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_event got cnt=%0d err=%b want 1 1", inv_cnt, err_sticky);
    end
    q_before = q;
    step('0, '0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (inv_cnt !== 3'd0 || err_sticky !== 1'b0 || q !== q_before) begin
      errors++;
      $display("FAIL clr_alone got cnt=%0d err=%b q=%h want 0 0 %h", inv_cnt, err_sticky, q, q_before);
    end
  endtask

  task automatic test_rst_toggle();
    repeat (4) step('1, '1, 2'd3, 1'b0, 1'b0);
    step('1, '1, 2'd3, 1'b0, 1'b1);
    checks++;
    if ({q, qbar, invalid, inv_cnt, err_sticky} !== {8'hA5, 8'h5A, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_override got q=%h qbar=%h inv=%h cnt=%0d err=%b want A5 5A 00 0 0",
               q, qbar, invalid, inv_cnt, err_sticky);
    end
  endtask

`ifdef SR_GLITCH_FILTER_EN
  task automatic test_filter();
    step('0, '0, 2'd0, 1'b0, 1'b1);
    step(8'h02, '0, 2'd0, 1'b0, 1'b0);
    step(8'h02, '0, 2'd0, 1'b0, 1'b0);
    step('0, '0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (q[1] !== 1'b0) begin
      errors++;
      $display("FAIL filter_short got q1=%b want 0", q[1]);
    end
    for (int k = 1; k <= 3; k++) begin
      step(8'h02, '0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (q[1] !== (k == 3)) begin
        errors++;
        $display("FAIL filter_long_%0d got q1=%b want %b", k, q[1], (k == 3));
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] rs;
    logic [N-1:0] rr;
    for (int k = 0; k < 300; k++) begin
      rs = N'($urandom);
      rr = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) rr = rs;
      step(rs, rr, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
      checks++;
      if ({q, qbar, invalid, inv_cnt, err_sticky} !== {m_q, ~m_q, m_inv, CNT_W'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL random_%0d got q=%h qbar=%h inv=%h cnt=%0d err=%b want %h %h %h %0d %b",
                 k, q, qbar, invalid, inv_cnt, err_sticky, m_q, ~m_q, m_inv, m_cnt, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; s = '0; r = '0; mode = 2'd0; err_clr = 1'b0;
    m_q = INIT; m_inv = '0; m_cnt = 0; m_err = 1'b0;
    test_reset();
    test_set_reset();
    test_modes();
    test_saturation();
    test_err_clr();
    test_rst_toggle();
`ifdef SR_GLITCH_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
